// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises instruction-bus and data-bus accesses onto a
// single-ported memory. One transaction in flight at most; the winner's
// direction, address and write data are held for the whole access, and read
// data returns with a one-cycle valid pulse after MEM_LAT cycles.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to replace the fixed
// data-over-instruction priority with a 1-bit last-owner round-robin pointer.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_i_req_i,
    input  logic        s_i_write_i,
    input  logic [31:0] s_i_add_i,
    input  logic [31:0] s_i_val_i,
    output logic        s_i_gnt_o,
    output logic        s_i_rvalid_o,
    output logic [31:0] s_i_val_o,
    input  logic        s_d_req_i,
    input  logic        s_d_write_i,
    input  logic [31:0] s_d_add_i,
    input  logic [31:0] s_d_val_i,
    output logic        s_d_gnt_o,
    output logic        s_d_rvalid_o,
    output logic [31:0] s_d_val_o,
    output logic        s_mem_req_o,
    output logic        s_mem_write_o,
    output logic [31:0] s_mem_add_o,
    output logic [31:0] s_mem_val_o,
    input  logic [31:0] s_mem_val_i,
    output logic        s_busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Counter preload: WAIT lasts MEM_LAT cycles, the last one capturing data.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;     // 1 = data requester owns the access
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        tie_win_d;            // winner when both requests are high

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_q, last_d;       // 1 = data was served last

    // On a tie, favour whichever requester was not served last.
    always_comb begin
        tie_win_d = ~last_q;
    end
`else
    // On a tie, data always wins.
    always_comb begin
        tie_win_d = 1'b1;
    end
`endif

    // State register and all latched fields; everything clears on reset.
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            owner_q   <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    // Next-state logic: arbitrate and latch in IDLE, count in WAIT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_i_req_i || s_d_req_i) begin
                    // A lone requester wins regardless of the tie rule.
                    if (s_i_req_i && s_d_req_i) begin
                        owner_d = tie_win_d;
                    end else begin
                        owner_d = s_d_req_i;
                    end
                    write_d = owner_d ? s_d_write_i : s_i_write_i;
                    addr_d  = owner_d ? s_d_add_i   : s_i_add_i;
                    wdata_d = owner_d ? s_d_val_i   : s_i_val_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
`ifdef ARB_ROUND_ROBIN_EN
                last_d = owner_q;
`endif
                if (write_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (owner_q) begin
                        d_rdata_d = s_mem_val_i;
                    end else begin
                        i_rdata_d = s_mem_val_i;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; address/data hold their last latched value.
    always_comb begin
        s_mem_req_o   = (state_q == ISSUE);
        s_mem_write_o = (state_q == ISSUE) && write_q;
        s_mem_add_o   = addr_q;
        s_mem_val_o   = wdata_q;
        s_i_gnt_o     = (state_q == ISSUE) && !owner_q;
        s_d_gnt_o     = (state_q == ISSUE) &&  owner_q;
        s_i_rvalid_o  = (state_q == RESP)  && !owner_q;
        s_d_rvalid_o  = (state_q == RESP)  &&  owner_q;
        s_i_val_o     = i_rdata_q;
        s_d_val_o     = d_rdata_q;
        s_busy_o      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: one instance at MEM_LAT=1 with a
// scoreboarded memory model, one at MEM_LAT=4 driven with changing read data.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0, i_write = 1'b0, d_req = 1'b0, d_write = 1'b0;
    logic [31:0] i_add = '0, i_wval = '0, d_add = '0, d_wval = '0;
    logic [31:0] mem1_rd = '0, mem4_val = '0;

    logic        i_gnt1, i_rv1, d_gnt1, d_rv1, mreq1, mwr1, busy1;
    logic [31:0] i_val1, d_val1, madd1, mval1;
    logic        i_gnt4, i_rv4, d_gnt4, d_rv4, mreq4, mwr4, busy4;
    logic [31:0] i_val4, d_val4, madd4, mval4;

    int n_cmp = 0;
    int n_err = 0;
    logic tb_last = 1'b0;  // model of "data served last"

    typedef struct packed {logic dsel; logic wr; logic [31:0] addr; logic [31:0] wd;} txn_t;
    typedef struct packed {logic dsel; logic [31:0] data;} rsp_t;
    txn_t txn_q[$];
    rsp_t rsp_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(1)) u_dut1 (
        .s_clk_i(clk), .s_resetn_i(rst_n),
        .s_i_req_i(i_req), .s_i_write_i(i_write), .s_i_add_i(i_add), .s_i_val_i(i_wval),
        .s_i_gnt_o(i_gnt1), .s_i_rvalid_o(i_rv1), .s_i_val_o(i_val1),
        .s_d_req_i(d_req), .s_d_write_i(d_write), .s_d_add_i(d_add), .s_d_val_i(d_wval),
        .s_d_gnt_o(d_gnt1), .s_d_rvalid_o(d_rv1), .s_d_val_o(d_val1),
        .s_mem_req_o(mreq1), .s_mem_write_o(mwr1), .s_mem_add_o(madd1), .s_mem_val_o(mval1),
        .s_mem_val_i(mem1_rd), .s_busy_o(busy1)
    );

    mem_port_arbiter #(.MEM_LAT(4)) u_dut4 (
        .s_clk_i(clk), .s_resetn_i(rst_n),
        .s_i_req_i(i_req), .s_i_write_i(i_write), .s_i_add_i(i_add), .s_i_val_i(i_wval),
        .s_i_gnt_o(i_gnt4), .s_i_rvalid_o(i_rv4), .s_i_val_o(i_val4),
        .s_d_req_i(d_req), .s_d_write_i(d_write), .s_d_add_i(d_add), .s_d_val_i(d_wval),
        .s_d_gnt_o(d_gnt4), .s_d_rvalid_o(d_rv4), .s_d_val_o(d_val4),
        .s_mem_req_o(mreq4), .s_mem_write_o(mwr4), .s_mem_add_o(madd4), .s_mem_val_o(mval4),
        .s_mem_val_i(mem4_val), .s_busy_o(busy4)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h100) return 32'h00A00093;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Winner prediction for the current request pattern.
    function automatic logic pick(input logic ir, input logic dr);
        if (dr && !ir) return 1'b1;
        if (ir && !dr) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        return ~tb_last;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dsel, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        if (dsel) begin
            d_req = 1'b1; d_write = wr; d_add = a; d_wval = wd;
        end else begin
            i_req = 1'b1; i_write = wr; i_add = a; i_wval = wd;
        end
    endtask

    task automatic expect_txn(input logic dsel, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic with_rsp);
        txn_q.push_back('{dsel: dsel, wr: wr, addr: a, wd: wd});
        if (!wr && with_rsp) rsp_q.push_back('{dsel: dsel, data: mem_f(a)});
        tb_last = dsel;
    endtask

    // Memory model for the MEM_LAT=1 instance: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (mreq1 && !mwr1) mem1_rd <= mem_f(madd1);
    end

    // Scoreboard: compare each memory strobe and each rvalid with the queues.
    always @(negedge clk) begin
        txn_t t;
        rsp_t r;
        if (rst_n) begin
            if (mreq1) begin
                if (txn_q.size() == 0) begin
                    chk("txn_extra", 64'd1, 64'd0);
                end else begin
                    t = txn_q.pop_front();
                    chk("txn_own", {62'd0, d_gnt1, i_gnt1}, t.dsel ? 64'd2 : 64'd1);
                    chk("txn_wr", {63'd0, mwr1}, {63'd0, t.wr});
                    chk("txn_add", {32'd0, madd1}, {32'd0, t.addr});
                    if (t.wr) chk("txn_wd", {32'd0, mval1}, {32'd0, t.wd});
                end
            end
            if (i_rv1 || d_rv1) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_extra", 64'd1, 64'd0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_own", {62'd0, d_rv1, i_rv1}, r.dsel ? 64'd2 : 64'd1);
                    chk("rsp_data", {32'd0, r.dsel ? d_val1 : i_val1}, {32'd0, r.data});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic w, l, seen;

        // Reset state
        tick(); tick();
        chk("rst_ctl1", {57'd0, i_gnt1, i_rv1, d_gnt1, d_rv1, mreq1, mwr1, busy1}, 64'd0);
        chk("rst_dat1", {32'd0, i_val1 | d_val1 | madd1 | mval1}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Single instruction read at 0x100
        drive(1'b0, 1'b0, 32'h100, 32'h0);
        expect_txn(1'b0, 1'b0, 32'h100, 32'h0, 1'b1);
        tick();
        chk("ird_gnt", {61'd0, i_gnt1, d_gnt1, mreq1}, 64'd5);
        chk("ird_add", {32'd0, madd1}, 64'h100);
        i_req = 1'b0;
        tick();
        chk("ird_wait", {62'd0, busy1, i_rv1}, 64'd2);
        tick();
        chk("ird_rv", {63'd0, i_rv1}, 64'd1);
        chk("ird_val", {32'd0, i_val1}, 64'h00A00093);
        tick();
        chk("ird_idle", {63'd0, busy1}, 64'd0);

        // Data write 0x200 <- 0xDEADBEEF
        drive(1'b1, 1'b1, 32'h200, 32'hDEADBEEF);
        expect_txn(1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0);
        tick();
        chk("dwr_ctl", {60'd0, d_gnt1, i_gnt1, mreq1, mwr1}, 64'b1011);
        chk("dwr_bus", {madd1, mval1}, {32'h200, 32'hDEADBEEF});
        d_req = 1'b0;
        tick();
        chk("dwr_after", {61'd0, busy1, mwr1, d_rv1}, 64'd0);
        chk("dwr_vals", {d_val1, i_val1}, {32'd0, 32'h00A00093});

        // Simultaneous reads: data 0x300, instruction 0x104
        w = pick(1'b1, 1'b1);
        l = ~w;
        drive(1'b1, 1'b0, 32'h300, 32'h0);
        drive(1'b0, 1'b0, 32'h104, 32'h0);
        expect_txn(w, 1'b0, w ? 32'h300 : 32'h104, 32'h0, 1'b1);
        expect_txn(l, 1'b0, l ? 32'h300 : 32'h104, 32'h0, 1'b1);
        tick();
        chk("tie_gnt1", {62'd0, d_gnt1, i_gnt1}, w ? 64'd2 : 64'd1);
        if (w) d_req = 1'b0; else i_req = 1'b0;
        tick();
        tick();
        chk("tie_rv1", {62'd0, d_rv1, i_rv1}, w ? 64'd2 : 64'd1);
        chk("tie_nogntl", {62'd0, d_gnt1, i_gnt1}, 64'd0);
        tick();
        chk("tie_idle", {63'd0, busy1}, 64'd0);
        tick();
        chk("tie_gnt2", {62'd0, d_gnt1, i_gnt1}, l ? 64'd2 : 64'd1);
        if (l) d_req = 1'b0; else i_req = 1'b0;
        tick(); tick();
        chk("tie_rv2", {62'd0, d_rv1, i_rv1}, l ? 64'd2 : 64'd1);
        tick();

        // Both requests held continuously (writes): grant order
        drive(1'b1, 1'b1, 32'h400, 32'h11111111);
        drive(1'b0, 1'b1, 32'h500, 32'h22222222);
        for (int k = 0; k < 4; k++) begin
            w = pick(1'b1, 1'b1);
            expect_txn(w, 1'b1, w ? 32'h400 : 32'h500, w ? 32'h11111111 : 32'h22222222, 1'b0);
            tick();
            chk($sformatf("seq_gnt%0d", k), {62'd0, d_gnt1, i_gnt1}, w ? 64'd2 : 64'd1);
            tick();
            chk($sformatf("seq_idle%0d", k), {63'd0, busy1}, 64'd0);
            if (k == 3) begin
                d_req = 1'b0; i_req = 1'b0;
            end
        end

        // Let both instances drain
        for (int k = 0; k < 12; k++) tick();
        chk("drain_busy", {62'd0, busy1, busy4}, 64'd0);

        // MEM_LAT=4 data read with changing memory data
        drive(1'b1, 1'b0, 32'h600, 32'h0);
        expect_txn(1'b1, 1'b0, 32'h600, 32'h0, 1'b1);
        tick();
        chk("l4_gnt", {31'd0, d_gnt4, madd4}, {31'd0, 1'b1, 32'h600});
        d_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            mem4_val = 32'h1000_0000 + 32'(k);
        end
        tick();
        mem4_val = 32'hCAFEF00D;
        chk("l4_wait", {62'd0, busy4, d_rv4}, 64'd2);
        tick();
        mem4_val = 32'h2000_0000;
        chk("l4_rv", {63'd0, d_rv4}, 64'd1);
        chk("l4_val", {32'd0, d_val4}, 64'hCAFEF00D);
        tick();
        chk("l4_hold", {31'd0, d_rv4, d_val4}, {31'd0, 1'b0, 32'hCAFEF00D});
        chk("l4_idle", {63'd0, busy4}, 64'd0);
        tick();

        // Reset in the middle of WAIT
        drive(1'b1, 1'b0, 32'h700, 32'h0);
        expect_txn(1'b1, 1'b0, 32'h700, 32'h0, 1'b0);
        tick();
        d_req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_ctl1", {57'd0, i_gnt1, i_rv1, d_gnt1, d_rv1, mreq1, mwr1, busy1}, 64'd0);
        chk("mr_ctl4", {57'd0, i_gnt4, i_rv4, d_gnt4, d_rv4, mreq4, mwr4, busy4}, 64'd0);
        chk("mr_dat1", {i_val1 | d_val1, madd1 | mval1}, 64'd0);
        chk("mr_dat4", {i_val4 | d_val4, madd4 | mval4}, 64'd0);
        tb_last = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            seen = seen | i_rv1 | d_rv1 | i_rv4 | d_rv4 | busy1 | busy4;
        end
        chk("mr_quiet", {63'd0, seen}, 64'd0);

        // Next request after reset completes normally
        mem4_val = 32'h0BADC0DE;
        drive(1'b0, 1'b0, 32'h108, 32'h0);
        expect_txn(1'b0, 1'b0, 32'h108, 32'h0, 1'b1);
        tick();
        chk("pr_gnt", {62'd0, i_gnt1, i_gnt4}, 64'd3);
        i_req = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("pr_rv4", {31'd0, i_rv4, i_val4}, {31'd0, 1'b1, 32'h0BADC0DE});
        chk("pr_val1", {32'd0, i_val1}, {32'd0, mem_f(32'h108)});
        tick(); tick();
        chk("sb_txn_left", 64'(txn_q.size()), 64'd0);
        chk("sb_rsp_left", 64'(rsp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing a single-ported memory between the CPU instruction bus and data bus. It sits between `cpu_top`'s ibus/dbus ports and a unified memory model. It serialises one transaction at a time, holds the winner's address, data and direction for the whole access, and returns read data with a single-cycle valid pulse after a configurable fixed memory read latency.

## Interface
Parameters:
- `MEM_LAT`, default 1: memory read latency in cycles, measured from the `s_mem_req_o` cycle to valid `s_mem_val_i`. Legal range 1..15.

Ports:
- `s_clk_i` in 1: clock. All state changes on the rising edge.
- `s_resetn_i` in 1: reset, asynchronous, active-low.
- `s_i_req_i` in 1: instruction requester, request.
- `s_i_write_i` in 1: instruction requester, 1 = write.
- `s_i_add_i` in 32: instruction requester, address.
- `s_i_val_i` in 32: instruction requester, write data.
- `s_i_gnt_o` out 1: instruction grant, 1-cycle pulse.
- `s_i_rvalid_o` out 1: instruction read data valid, 1-cycle pulse.
- `s_i_val_o` out 32: instruction read data.
- `s_d_req_i`, `s_d_write_i`, `s_d_add_i`, `s_d_val_i`, `s_d_gnt_o`, `s_d_rvalid_o`, `s_d_val_o`: data requester, same widths and meanings.
- `s_mem_req_o` out 1: memory access strobe, 1 cycle per transaction.
- `s_mem_write_o` out 1: memory write enable. Valid only while `s_mem_req_o` = 1.
- `s_mem_add_o` out 32: memory address.
- `s_mem_val_o` out 32: memory write data.
- `s_mem_val_i` in 32: memory read data.
- `s_busy_o` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. There is one outstanding transaction at most.
- IDLE, transition:
  - If any request is high at the edge, latch the winner's owner, write, addr and wdata into internal registers, then go to ISSUE.
  - Otherwise stay in IDLE.
  - Requests are sampled only in IDLE.
- ISSUE, outputs:
  - `s_mem_req_o` = 1.
  - `s_mem_write_o` = latched write.
  - `s_mem_add_o` and `s_mem_val_o` = latched values.
  - `s_x_gnt_o` = 1 for the owner only.
- ISSUE, transition: a write goes to IDLE. A read loads the counter with `MEM_LAT`-1 and goes to WAIT.
- WAIT:
  - If counter ≠ 0, decrement it.
  - If counter = 0, capture `s_mem_val_i` into the owner's read-data register and go to RESP.
- RESP: `s_x_rvalid_o` = 1 for the owner only. Next state is IDLE.
- `s_i_val_o` and `s_d_val_o` each hold their last captured read until that requester's next read completes. Writes never change them.
- `s_mem_add_o` and `s_mem_val_o` hold the last latched values outside ISSUE. `s_mem_write_o` is gated to 0 outside ISSUE.
- Arbitration (default): when both requests are high in IDLE, data wins. Instruction waits until the data transaction completes and its request is re-sampled.
- Requester contract: hold req and all fields stable until gnt, then drop req in the cycle after gnt. A req still high in IDLE after completion is treated as a new transaction.
- A single requester may issue back-to-back transactions, one every 2 cycles for writes and every `MEM_LAT`+3 cycles for reads.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM returns to IDLE and the counter is cleared.
  - All latched fields are cleared.
  - All outputs are 0, including `s_x_val_o` and `s_mem_add_o`.
  - An in-flight transaction is dropped with no gnt or rvalid afterwards.
  - The round-robin pointer resets to "instruction served last".
- Request seen at edge T (IDLE):
  - gnt and `s_mem_req_o` are high in cycle T+1.
  - For a write, the FSM is back in IDLE at T+2.
  - For a read, WAIT covers T+2..T+1+`MEM_LAT`, rvalid is high in cycle T+2+`MEM_LAT`, and the FSM is in IDLE at T+3+`MEM_LAT`.
- `s_busy_o` is high in every non-IDLE cycle.
- A request arriving while busy is ignored until IDLE. No queueing.

## Configuration
- Macro: `ARB_ROUND_ROBIN_EN`.
- Defined:
  - A 1-bit last-owner pointer updates on every grant.
  - On simultaneous requests, the requester that was not served last wins.
  - The first tie after reset goes to data. Ties then alternate.
  - A single active requester always wins, whatever the pointer says.
- Undefined: fixed data-over-instruction priority, and no pointer register exists.

## Test plan
- Single instruction read, `MEM_LAT`=1: memory returns 0x00A00093 at addr 0x100. Pulse `s_i_req_i` (addr 0x100) at T → `s_i_gnt_o` and `s_mem_req_o` high at T+1 with `s_mem_add_o`=0x100. `s_i_rvalid_o` high at T+3 with `s_i_val_o`=0x00A00093.
- Data write: `s_d_write_i`=1, addr 0x200, data 0xDEADBEEF → `s_mem_write_o`=1 for exactly one cycle with matching addr and data. No `s_d_rvalid_o`. `s_busy_o` is low at T+2.
- Simultaneous requests, macro off: data read 0x300 and instruction read 0x104 asserted together → data is granted first. Instruction is granted only after data rvalid. The rvalids arrive on the correct requesters with the correct data.
- Simultaneous requests, macro on, both held continuously: the grant sequence is D, I, D, I.
- `MEM_LAT`=4 read: rvalid at T+6. Memory data changing in every WAIT cycle except the last must not appear on `s_x_val_o`.
- Reset asserted mid-WAIT → all outputs 0 immediately. No rvalid after release. The next request completes normally.
